// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int INSN_BYTES    = 4;
    localparam int PC_ALIGN_BITS = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer; flush drops all entries but a same-cycle pop still completes.
module fetch_fifo #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push_i,
    input  logic                            pop_i,
    input  logic                            flush_i,
    input  logic [DATA_W-1:0]               data_i,
    output logic                            full_o,
    output logic [$clog2(FIFO_DEPTH):0]     count_o,
    output logic [DATA_W-1:0]               head_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;

    assign do_push = push_i && !flush_i;
    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            // Pointers re-align to zero; the popped head needs no bookkeeping.
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (pop_i)   rd_d = rd_q + PTR_W'(1);
            if (do_push && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (pop_i && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (do_push) mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/insn_fetch.sv
// Fetch PC and redirect control; captures {pc, insn} from a combinational memory into the fetch buffer.
module insn_fetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INSN_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [INSN_WIDTH-1:0] insn,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSN_WIDTH-1:0] out_insn,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int ENTRY_W = ADDR_WIDTH + INSN_WIDTH;

    logic [ADDR_WIDTH-1:0]         fpc_q, fpc_d;
    logic                          pop, push;
    logic                          fifo_full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [ENTRY_W-1:0]            fifo_head;

    assign read_address = fpc_q;
    assign out_valid    = (fifo_count != '0);
    assign pop          = out_valid && out_ready;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push         = fetch_en && !redirect_valid && (!fifo_full || pop);
    assign out_pc       = fifo_head[ENTRY_W-1:INSN_WIDTH];
    assign out_insn     = fifo_head[INSN_WIDTH-1:0];

    always_comb begin
        fpc_d = fpc_q;
        if (redirect_valid)
            fpc_d = {redirect_pc[ADDR_WIDTH-1:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};
        else if (push)
            fpc_d = fpc_q + ADDR_WIDTH'(INSN_BYTES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fpc_q <= RESET_PC;
        else        fpc_q <= fpc_d;
    end

    fetch_fifo #(
        .DATA_W     (ENTRY_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  ({fpc_q, insn}),
        .full_o  (fifo_full),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

endmodule
